// File: rtl/tiny_axi_arb_pkg.sv
// Shared types and constants for the AXI address-channel arbiter.
package tiny_axi_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ATOP_W = 6;
    localparam int MAX_M      = 8;

    function automatic logic [MAX_M-1:0] onehot(input logic [2:0] idx);
        logic [MAX_M-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_idx, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic found;
    int   k;

    // Offset 1..N so the previous owner is examined last and can still be re-granted.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_idx) + i) % N;
            if (!found && req[k]) begin
                pick  = IW'(k);
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/req_bus_arbiter.sv
// Round-robin arbiter sharing one AXI AW/AR channel among NUM_M managers.
// Optional grant timeout (adds tmo_pulse port) when ARB_TIMEOUT_EN is defined.
module req_bus_arbiter
    import tiny_axi_arb_pkg::*;
#(
    parameter  int NUM_M      = 4,
    parameter  int TMO_CYCLES = 16,
    localparam int IW         = $clog2(NUM_M)
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_M-1:0]            req_rq,
    output logic [NUM_M-1:0]            gnt_rq,
    input  logic [NUM_M-1:0]            m_a_valid,
    output logic [NUM_M-1:0]            m_a_ready,
    input  logic [AXI_ID_W*NUM_M-1:0]   m_a_id,
    input  logic [AXI_ADDR_W*NUM_M-1:0] m_a_addr,
    input  logic [AXI_ATOP_W*NUM_M-1:0] m_a_atop,
    output logic                        s_a_valid,
    input  logic                        s_a_ready,
    output logic [AXI_ID_W-1:0]         s_a_id,
    output logic [AXI_ADDR_W-1:0]       s_a_addr,
    output logic [AXI_ATOP_W-1:0]       s_a_atop,
    output logic [IW-1:0]               gnt_idx,
`ifdef ARB_TIMEOUT_EN
    output logic                        tmo_pulse,
`endif
    output logic                        busy
);

    arb_state_t       state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    pick;
    logic             any_req;
    logic             hs;
    logic             tmo_hit;
    logic [MAX_M-1:0] oh;

    logic [AXI_ID_W-1:0]   id_arr   [NUM_M];
    logic [AXI_ADDR_W-1:0] addr_arr [NUM_M];
    logic [AXI_ATOP_W-1:0] atop_arr [NUM_M];

    rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
        .req      (req_rq),
        .last_idx (last_q),
        .pick     (pick),
        .any      (any_req)
    );

    for (genvar g = 0; g < NUM_M; g++) begin : g_lane
        assign id_arr[g]    = m_a_id[g*AXI_ID_W +: AXI_ID_W];
        assign addr_arr[g]  = m_a_addr[g*AXI_ADDR_W +: AXI_ADDR_W];
        assign atop_arr[g]  = m_a_atop[g*AXI_ATOP_W +: AXI_ATOP_W];
        assign m_a_ready[g] = s_a_ready & busy & (idx_q == IW'(g));
    end

    assign busy      = (state_q == ARB_GRANT);
    assign gnt_rq    = gnt_q;
    assign gnt_idx   = idx_q;
    assign s_a_valid = busy & m_a_valid[idx_q];
    assign s_a_id    = busy ? id_arr[idx_q]   : '0;
    assign s_a_addr  = busy ? addr_arr[idx_q] : '0;
    assign s_a_atop  = busy ? atop_arr[idx_q] : '0;
    assign hs        = s_a_valid & s_a_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q;

    // Only idle-valid cycles count; once valid is up the grant must stay until ready.
    always_comb begin
        cnt_d   = cnt_q;
        tmo_hit = 1'b0;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else if (!m_a_valid[idx_q]) begin
            if (cnt_q == CW'(TMO_CYCLES - 1)) tmo_hit = 1'b1;
            else                              cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_hit & ~hs & req_rq[idx_q] & busy;
        end
    end

    assign tmo_pulse = tmo_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        oh      = onehot(3'(pick));
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    gnt_d   = oh[NUM_M-1:0];
                    idx_d   = pick;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hs || !req_rq[idx_q] || tmo_hit) begin
                    gnt_d   = '0;
                    last_d  = idx_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule
